// File: rtl/memsync_axi_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between the per-bank MEMSync engines.
// One fixed-length burst per grant; the block owns address, B and R-last handshakes.
module memsync_axi_arbiter #(
    parameter int NREQ           = 16,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH   = 8,
    parameter int BEATS          = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ-1:0]                req_wr,
    input  logic [NREQ*AXI_ADDR_WIDTH-1:0] req_addr,
    output logic [NREQ-1:0]                gnt,
    output logic [NREQ-1:0]                done,
    output logic                           err,
    output logic                           busy,
    input  logic [AXI_DATA_WIDTH-1:0]      s_wdata,
    output logic                           s_wready,
    output logic [AXI_DATA_WIDTH-1:0]      s_rdata,
    output logic                           s_rvalid,
    output logic [AXI_ID_WIDTH-1:0]        m_axi_awid,
    output logic [AXI_ADDR_WIDTH-1:0]      m_axi_awaddr,
    output logic [7:0]                     m_axi_awlen,
    output logic [2:0]                     m_axi_awsize,
    output logic [1:0]                     m_axi_awburst,
    output logic                           m_axi_awvalid,
    input  logic                           m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]      m_axi_wdata,
    output logic [AXI_STRB_WIDTH-1:0]      m_axi_wstrb,
    output logic                           m_axi_wlast,
    output logic                           m_axi_wvalid,
    input  logic                           m_axi_wready,
    input  logic [1:0]                     m_axi_bresp,
    input  logic                           m_axi_bvalid,
    output logic                           m_axi_bready,
    output logic [AXI_ID_WIDTH-1:0]        m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                     m_axi_arlen,
    output logic [2:0]                     m_axi_arsize,
    output logic [1:0]                     m_axi_arburst,
    output logic                           m_axi_arvalid,
    input  logic                           m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
    input  logic [1:0]                     m_axi_rresp,
    input  logic                           m_axi_rlast,
    input  logic                           m_axi_rvalid,
    output logic                           m_axi_rready
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // state   | meaning
    // IDLE    | scanning req from ptr, no transaction open
    // ADDR    | AW or AR valid held until ready
    // WDATA   | streaming BEATS write beats from the granted engine
    // WRESP   | waiting for the write response
    // RDATA   | forwarding read beats until rlast
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_WRESP = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;

    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    logic [2:0]                state_q, state_d;
    logic [IDXW-1:0]           ptr_q, ptr_d;
    logic [IDXW-1:0]           idx_q, idx_d;
    logic                      wr_q, wr_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      err_acc_q, err_acc_d;
    logic [NREQ-1:0]           gnt_q, gnt_d;
    logic [NREQ-1:0]           done_q, done_d;
    logic                      err_q, err_d;

    logic                      pick_vld;
    logic [IDXW-1:0]           pick_idx;
    logic [IDXW-1:0]           ptr_next;
    int                        cand;

    // First set request at or after ptr, wrapping.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        cand     = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = IDXW'(cand);
            end
        end
    end

    assign ptr_next = (idx_q == IDXW'(NREQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        err_acc_d = err_acc_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    idx_d           = pick_idx;
                    wr_d            = req_wr[pick_idx];
                    addr_d          = req_addr[pick_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    cnt_d           = '0;
                    err_acc_d       = 1'b0;
                    state_d         = S_ADDR;
                end
            end
            S_ADDR: begin
                if (wr_q && m_axi_awready)       state_d = S_WDATA;
                else if (!wr_q && m_axi_arready) state_d = S_RDATA;
            end
            S_WDATA: begin
                if (m_axi_wready) begin
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = S_WRESP;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    done_d  = gnt_q;
                    err_d   = |m_axi_bresp;
                    gnt_d   = '0;
                    ptr_d   = ptr_next;
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    if (m_axi_rlast) begin
                        done_d    = gnt_q;
                        err_d     = err_acc_q | (|m_axi_rresp);
                        err_acc_d = 1'b0;
                        gnt_d     = '0;
                        ptr_d     = ptr_next;
                        state_d   = S_IDLE;
                    end else begin
                        err_acc_d = err_acc_q | (|m_axi_rresp);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            err_acc_q <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            err_acc_q <= err_acc_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign err  = err_q;
    assign busy = (state_q != S_IDLE);

    assign m_axi_awid    = AXI_ID_WIDTH'(idx_q);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = LAST_BEAT;
    assign m_axi_awsize  = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == S_ADDR) && wr_q;

    assign m_axi_wdata   = s_wdata;
    assign m_axi_wstrb   = '1;
    assign m_axi_wvalid  = (state_q == S_WDATA);
    assign m_axi_wlast   = (state_q == S_WDATA) && (cnt_q == LAST_BEAT);
    assign s_wready      = (state_q == S_WDATA) && m_axi_wready;

    assign m_axi_bready  = (state_q == S_WRESP);

    assign m_axi_arid    = AXI_ID_WIDTH'(idx_q);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = LAST_BEAT;
    assign m_axi_arsize  = 3'($clog2(AXI_STRB_WIDTH));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == S_ADDR) && !wr_q;

    assign m_axi_rready  = (state_q == S_RDATA);
    assign s_rvalid      = (state_q == S_RDATA) && m_axi_rvalid;
    assign s_rdata       = m_axi_rdata;

endmodule

// File: doc/memsync_axi_arbiter.md
# memsync_axi_arbiter

Round-robin arbiter that shares the DIMM's single AXI master port between the per-bank MEMSync engines. Each engine (one per bank group/bank pair) requests one fixed-length burst at a time: a read to allocate a row into the Emulation Memory Cache, or a write to write a row back to board memory. The block owns the address, write-response and read-last handshakes and steers the data beats to and from the granted engine. It sits between the per-bank MEMSync logic and the DIMM-level `m_axi_*` ports.

## Interface
- NREQ, 16, number of requesters (BANKGROUPS*BANKSPERGROUP); requester index i = bg*BANKSPERGROUP+ba
- AXI_ADDR_WIDTH, 16, AXI address width
- AXI_DATA_WIDTH, 32, AXI data width; AXI_STRB_WIDTH = AXI_DATA_WIDTH/8
- AXI_ID_WIDTH, 8, AXI ID width; must hold NREQ-1
- BEATS, 16, beats per burst (1..256); awlen/arlen = BEATS-1
- clk  in  1  block clock (the DIMM's gated clk)
- reset_n  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester transfer request, level
- req_wr  in  NREQ  1 = writeback (AXI write), 0 = allocate (AXI read)
- req_addr  in  NREQ*AXI_ADDR_WIDTH  flattened burst start addresses; requester i occupies slice i
- gnt  out  NREQ  one-hot grant, held for the whole transaction
- done  out  NREQ  one-cycle completion pulse to the granted requester
- err  out  1  pulses with done when any bresp/rresp of that burst was nonzero
- busy  out  1  high in every state except IDLE
- s_wdata  in  AXI_DATA_WIDTH  write beat from the granted requester (muxed outside)
- s_wready  out  1  beat consumed this cycle; requester advances to its next beat
- s_rdata  out  AXI_DATA_WIDTH  read beat to the granted requester (= m_axi_rdata)
- s_rvalid  out  1  s_rdata valid this cycle
- m_axi_awid/awaddr/awlen/awvalid, m_axi_awready  out/in  per AXI4  write address channel; awsize = log2(AXI_STRB_WIDTH), awburst = INCR
- m_axi_wdata/wstrb/wlast/wvalid, m_axi_wready  out/in  per AXI4  write data channel; wstrb all ones
- m_axi_bresp/bvalid, m_axi_bready  in/out  per AXI4  write response channel
- m_axi_arid/araddr/arlen/arvalid, m_axi_arready  out/in  per AXI4  read address channel; arsize/arburst as for AW
- m_axi_rdata/rresp/rlast/rvalid, m_axi_rready  in/out  per AXI4  read data channel

## Operation
- States: IDLE, ADDR, WDATA, WRESP, RDATA.
- IDLE: the block scans req starting at round-robin pointer ptr (wrapping NREQ-1 to 0) and picks the first set bit k. It registers k, req_wr[k] and addr slice k, drives gnt=onehot(k) and goes to ADDR. With no request it stays in IDLE.
- ADDR: awvalid (if write) or arvalid (if read) is held high with awaddr/araddr = captured address and ID = k. On the ready handshake the valid drops; writes go to WDATA, reads go to RDATA.
- WDATA: wvalid=1, wdata=s_wdata, s_wready=m_axi_wready. An 8-bit beat counter increments on each wvalid&wready. wlast=1 when the counter equals BEATS-1. The last beat's handshake moves the FSM to WRESP.
- WRESP: bready=1. On bvalid the block pulses done[k] (and err if bresp!=0), clears gnt, sets ptr=(k+1) mod NREQ and returns to IDLE.
- RDATA: rready=1, s_rvalid=m_axi_rvalid. err_acc ORs in (rresp!=0) on each beat. The beat with rlast pulses done[k], sets err=err_acc|(rresp!=0), updates ptr as above and returns to IDLE. The beat counter is ignored for reads; completion is on rlast.
- req and req_addr are sampled only in IDLE. A requester that drops req mid-transaction does not abort it. done and err are registered.

## Timing
- Reset: state=IDLE, ptr=0, counter=0, err_acc=0. All outputs are 0: gnt, done, err, busy, every valid/ready/last, awaddr, araddr, awid, arid and awlen/arlen-independent regs. Reset mid-burst abandons the AXI transaction with no done.
- Request to valid: IDLE at cycle n with req set, then gnt/awvalid or arvalid high at n+1. Minimum write burst is 1 (ADDR) + BEATS (WDATA) + 1 (WRESP) cycles.
- done is asserted on the cycle after the bvalid or rlast handshake; gnt drops on that same cycle and busy drops with it. A new arbitration can start that cycle, so the next gnt appears one cycle later.
- The address-channel valid never deasserts before its ready. wvalid is continuous through WDATA (requesters always have data).
- Requests arriving during a transaction wait. A request is granted within NREQ transactions (round-robin fairness).

## Test plan
- Single read: req[3]=1, req_wr=0, addr 0x0400, BEATS=16 -> araddr=0x0400, arid=3, arlen=15; 16 s_rvalid beats; done[3] one cycle after rlast; err=0.
- Single write with wready stalled every other cycle -> exactly 16 W handshakes, wlast only on the 16th, done[0] after bvalid.
- req[0], req[5] and req[15] all held high -> grant order 0,5,15,0…; with ptr=6 -> 15,0,5.
- bresp=2'b10 on a write; rresp=SLVERR on beat 4 of a read only -> err pulses with done in both cases; the following clean burst gives err=0.
- reset_n asserted low during WDATA beat 7 -> all outputs 0 immediately; after release, req[2] gives gnt[2] from the normal IDLE path.
- Requester drops req after grant and awready held low 10 cycles -> awvalid held high for all 10 cycles; the transaction completes with done.
